phv_out_fifo: RTL and testbench

- Elastic buffer between a match-action stage's PHV output and the downstream consumer (next-stage arbiter or deparser).
- The stage emits PHVs with valid only and cannot be stalled. This block adds a valid/ready handshake on its output, raises almost_full so upstream can throttle the parser, and counts PHVs dropped on overflow.
- First-word-fall-through storage with status and statistics.

---
 rtl/phv_out_fifo.sv | 90 +++++++++
 tb/tb_phv_out_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/phv_out_fifo.sv
// Elastic FWFT buffer between a non-stallable PHV stage and a valid/ready consumer; 1-cycle write-to-head latency.
// Input has no backpressure: almost_full asks upstream to throttle, and arrivals while full are dropped and counted.
module phv_out_fifo #(
  parameter int PHV_LEN    = 1124,
  parameter int DEPTH_BITS = 4,
  parameter int AF_THRESH  = 12,
  parameter int CNT_W      = 32
) (
  input  logic                  axis_clk,
  input  logic                  aresetn,
  input  logic [PHV_LEN-1:0]    phv_in,
  input  logic                  phv_in_valid,
  output logic [PHV_LEN-1:0]    phv_out,
  output logic                  phv_out_valid,
  input  logic                  phv_out_ready,
  output logic                  almost_full,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [DEPTH_BITS:0]   occupancy,
  output logic [DEPTH_BITS:0]   hwm,
  output logic [CNT_W-1:0]      drop_cnt,
  input  logic                  stats_clr
);

  localparam int                DEPTH   = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_V = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] AF_V    = (DEPTH_BITS+1)'(AF_THRESH);
  localparam logic [DEPTH_BITS:0] OCC_ONE = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

  logic [PHV_LEN-1:0]    mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   occ_nxt;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Flags come straight from the registered count, so an arrival while full is dropped even if a pop frees a slot.
  assign fifo_full     = (occupancy == DEPTH_V);
  assign fifo_empty    = (occupancy == '0);
  assign almost_full   = (occupancy >= AF_V);
  assign phv_out_valid = ~fifo_empty;
  assign phv_out       = mem[rd_ptr];

  assign push = phv_in_valid & ~fifo_full;
  assign drop = phv_in_valid &  fifo_full;
  assign pop  = phv_out_valid & phv_out_ready;

  always_comb begin
    occ_nxt = occupancy;
    if (push && !pop) begin
      occ_nxt = occupancy + OCC_ONE;
    end else if (pop && !push) begin
      occ_nxt = occupancy - OCC_ONE;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (push) begin
      mem[wr_ptr] <= phv_in;
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      occupancy <= occ_nxt;
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      hwm      <= '0;
      drop_cnt <= '0;
    end else if (stats_clr) begin
      hwm      <= occ_nxt;
      drop_cnt <= CNT_W'(drop);
    end else begin
      if (occ_nxt > hwm) hwm <= occ_nxt;
      if (drop && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_phv_out_fifo.sv
// Directed bench for phv_out_fifo: scoreboard of accepted PHVs plus a reference occupancy/stats model.
module tb_phv_out_fifo;

  localparam int PHV_LEN = 1124;
  localparam int DB      = 4;
  localparam int DEPTH   = 16;

  logic               axis_clk = 1'b0;
  logic               aresetn;
  logic [PHV_LEN-1:0] phv_in;
  logic               phv_in_valid;
  logic [PHV_LEN-1:0] phv_out;
  logic               phv_out_valid;
  logic               phv_out_ready;
  logic               almost_full;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DB:0]        occupancy;
  logic [DB:0]        hwm;
  logic [31:0]        drop_cnt;
  logic               stats_clr;

  // Narrow drop counter instance for saturation
  logic [PHV_LEN-1:0] s_phv_in;
  logic               s_valid;
  logic [PHV_LEN-1:0] s_phv_out;
  logic               s_out_valid;
  logic               s_af, s_full, s_empty;
  logic [DB:0]        s_occ, s_hwm;
  logic [3:0]         s_drop;

  int checks = 0;
  int errors = 0;

  logic [PHV_LEN-1:0] sb [$];
  int m_occ, m_hwm;
  longint m_drop;

  always #5 axis_clk = ~axis_clk;

  phv_out_fifo #(.PHV_LEN(PHV_LEN), .DEPTH_BITS(DB), .AF_THRESH(12), .CNT_W(32)) dut (
    .axis_clk(axis_clk), .aresetn(aresetn), .phv_in(phv_in), .phv_in_valid(phv_in_valid),
    .phv_out(phv_out), .phv_out_valid(phv_out_valid), .phv_out_ready(phv_out_ready),
    .almost_full(almost_full), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .occupancy(occupancy), .hwm(hwm), .drop_cnt(drop_cnt), .stats_clr(stats_clr)
  );

  phv_out_fifo #(.PHV_LEN(PHV_LEN), .DEPTH_BITS(DB), .AF_THRESH(12), .CNT_W(4)) dut_sat (
    .axis_clk(axis_clk), .aresetn(aresetn), .phv_in(s_phv_in), .phv_in_valid(s_valid),
    .phv_out(s_phv_out), .phv_out_valid(s_out_valid), .phv_out_ready(1'b0),
    .almost_full(s_af), .fifo_full(s_full), .fifo_empty(s_empty),
    .occupancy(s_occ), .hwm(s_hwm), .drop_cnt(s_drop), .stats_clr(1'b0)
  );

  task automatic chk(input string tag, input logic [PHV_LEN-1:0] obs, input logic [PHV_LEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; outputs checked before the edge (head data) and after it (state).
  task automatic step(input logic vin, input logic [PHV_LEN-1:0] d, input logic rdy, input logic clr);
    logic push_m, pop_m, drop_m;
    logic [PHV_LEN-1:0] exp_d;
    phv_in_valid  = vin;
    phv_in        = d;
    phv_out_ready = rdy;
    stats_clr     = clr;
    #1;
    chk("out_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(m_occ != 0));
    push_m = vin && (m_occ < DEPTH);
    pop_m  = rdy && (m_occ != 0);
    drop_m = vin && !push_m;
    if (pop_m && sb.size() != 0) begin
      exp_d = sb.pop_front();
      chk("phv_out", phv_out, exp_d);
    end
    if (push_m) sb.push_back(d);
    m_occ = m_occ + int'(push_m) - int'(pop_m);
    if (clr) begin
      m_drop = longint'(drop_m);
      m_hwm  = m_occ;
    end else begin
      if (drop_m && m_drop != 64'hFFFF_FFFF) m_drop++;
      if (m_occ > m_hwm) m_hwm = m_occ;
    end
    @(posedge axis_clk);
    #1;
    phv_in_valid  = 1'b0;
    phv_out_ready = 1'b0;
    stats_clr     = 1'b0;
    chk("occupancy", PHV_LEN'(occupancy), PHV_LEN'(m_occ));
    chk("hwm", PHV_LEN'(hwm), PHV_LEN'(m_hwm));
    chk("drop_cnt", PHV_LEN'(drop_cnt), PHV_LEN'(m_drop));
    chk("fifo_full", PHV_LEN'(fifo_full), PHV_LEN'(m_occ == DEPTH));
    chk("fifo_empty", PHV_LEN'(fifo_empty), PHV_LEN'(m_occ == 0));
    chk("almost_full", PHV_LEN'(almost_full), PHV_LEN'(m_occ >= 12));
  endtask

  task automatic drain();
    while (m_occ != 0) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    aresetn = 1'b0; phv_in = '0; phv_in_valid = 1'b0; phv_out_ready = 1'b0; stats_clr = 1'b0;
    s_phv_in = '0; s_valid = 1'b0;
    m_occ = 0; m_hwm = 0; m_drop = 0;
    repeat (2) @(posedge axis_clk);
    #1;
    chk("rst_occ", PHV_LEN'(occupancy), '0);
    chk("rst_empty", PHV_LEN'(fifo_empty), PHV_LEN'(1));
    chk("rst_valid", PHV_LEN'(phv_out_valid), '0);
    chk("rst_full", PHV_LEN'(fifo_full), '0);
    chk("rst_af", PHV_LEN'(almost_full), '0);
    chk("rst_hwm", PHV_LEN'(hwm), '0);
    chk("rst_drop", PHV_LEN'(drop_cnt), '0);
    aresetn = 1'b1;
    @(posedge axis_clk);
    #1;

    // Three PHVs held, then drained back-to-back
    step(1'b1, PHV_LEN'(1), 1'b0, 1'b0);
    step(1'b1, PHV_LEN'(2), 1'b0, 1'b0);
    step(1'b1, PHV_LEN'(3), 1'b0, 1'b0);
    chk("three_occ", PHV_LEN'(occupancy), PHV_LEN'(3));
    chk("three_head", phv_out, PHV_LEN'(1));
    chk("three_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(1));
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    chk("three_empty", PHV_LEN'(fifo_empty), PHV_LEN'(1));

    // Fill to full, overflow twice, then overflow with a coincident pop
    for (int i = 0; i < 16; i++) begin
      step(1'b1, PHV_LEN'(32'h100 + i), 1'b0, 1'b0);
      if (i == 10) chk("af_before", PHV_LEN'(almost_full), '0);
      if (i == 11) chk("af_at12", PHV_LEN'(almost_full), PHV_LEN'(1));
      if (i == 14) chk("full_before", PHV_LEN'(fifo_full), '0);
    end
    chk("full_at16", PHV_LEN'(fifo_full), PHV_LEN'(1));
    step(1'b1, PHV_LEN'(32'hBAD0), 1'b0, 1'b0);
    step(1'b1, PHV_LEN'(32'hBAD1), 1'b0, 1'b0);
    chk("ovf_drop", PHV_LEN'(drop_cnt), PHV_LEN'(2));
    chk("ovf_occ", PHV_LEN'(occupancy), PHV_LEN'(16));
    chk("ovf_hwm", PHV_LEN'(hwm), PHV_LEN'(16));
    step(1'b1, PHV_LEN'(32'hBAD2), 1'b1, 1'b0);
    chk("full_pop_drop", PHV_LEN'(drop_cnt), PHV_LEN'(3));
    chk("full_pop_occ", PHV_LEN'(occupancy), PHV_LEN'(15));
    drain();

    // Push and ready together while empty: push only, not visible yet
    step(1'b1, PHV_LEN'(32'h77), 1'b1, 1'b0);
    chk("empty_push_occ", PHV_LEN'(occupancy), PHV_LEN'(1));
    drain();

    // Steady state at occupancy 5 across pointer wraps
    for (int i = 0; i < 5; i++) step(1'b1, PHV_LEN'(32'h200 + i), 1'b0, 1'b0);
    for (int i = 5; i < 45; i++) step(1'b1, {$urandom(), PHV_LEN'(32'h200 + i)}, 1'b1, 1'b0);
    chk("stream_occ", PHV_LEN'(occupancy), PHV_LEN'(5));
    drain();

    // stats_clr coincident with a drop, then without
    for (int i = 0; i < 16; i++) step(1'b1, PHV_LEN'(32'h300 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, PHV_LEN'(32'hDD), 1'b0, 1'b0);
    chk("drop7", PHV_LEN'(drop_cnt), PHV_LEN'(7));
    step(1'b1, PHV_LEN'(32'hDE), 1'b0, 1'b1);
    chk("clr_drop", PHV_LEN'(drop_cnt), PHV_LEN'(1));
    chk("clr_hwm", PHV_LEN'(hwm), PHV_LEN'(16));
    repeat (9) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("clr2_hwm", PHV_LEN'(hwm), PHV_LEN'(6));
    chk("clr2_drop", PHV_LEN'(drop_cnt), '0);
    drain();

    // Asynchronous reset mid-burst at occupancy 9
    for (int i = 0; i < 9; i++) step(1'b1, PHV_LEN'(32'h400 + i), 1'b0, 1'b0);
    phv_in_valid = 1'b1;
    phv_in = PHV_LEN'(32'h4FF);
    #1;
    aresetn = 1'b0;
    #1;
    chk("arst_valid", PHV_LEN'(phv_out_valid), '0);
    chk("arst_occ", PHV_LEN'(occupancy), '0);
    chk("arst_empty", PHV_LEN'(fifo_empty), PHV_LEN'(1));
    phv_in_valid = 1'b0;
    sb.delete();
    m_occ = 0; m_hwm = 0; m_drop = 0;
    #1;
    aresetn = 1'b1;
    @(posedge axis_clk);
    #1;
    step(1'b1, PHV_LEN'(32'hAB), 1'b0, 1'b0);
    chk("post_rst_head", phv_out, PHV_LEN'(32'hAB));
    chk("post_rst_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(1));
    chk("post_rst_occ", PHV_LEN'(occupancy), PHV_LEN'(1));
    drain();

    // Saturation of a 4-bit drop counter
    s_valid = 1'b1;
    for (int i = 0; i < 16 + 15; i++) begin
      s_phv_in = PHV_LEN'(i);
      @(posedge axis_clk);
      #1;
    end
    chk("sat_at15", PHV_LEN'(s_drop), PHV_LEN'(15));
    repeat (3) begin
      @(posedge axis_clk);
      #1;
    end
    s_valid = 1'b0;
    chk("sat_hold", PHV_LEN'(s_drop), PHV_LEN'(15));
    chk("sat_occ", PHV_LEN'(s_occ), PHV_LEN'(16));
    chk("sat_head", s_phv_out, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
